// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: digit-code constants and scan FSM states shared by the
// seven-segment display blocks.
package seven_seg_pkg;

    localparam logic [3:0] DIG_MINUS = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd11;

    typedef enum logic [1:0] {S_OFF, S_ON, S_BLANK} state_e;

endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: digit code to {a..g} segment pattern.
// Codes 0..9 are digits, 10 lights only 'g' (minus), 11..15 are blank.
module seven_seg_decoder #(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_hi;

    always_comb begin
        case (code_i)
            4'd0:    seg_hi = 7'b1111110;
            4'd1:    seg_hi = 7'b0110000;
            4'd2:    seg_hi = 7'b1101101;
            4'd3:    seg_hi = 7'b1111001;
            4'd4:    seg_hi = 7'b0110011;
            4'd5:    seg_hi = 7'b1011011;
            4'd6:    seg_hi = 7'b1011111;
            4'd7:    seg_hi = 7'b1110000;
            4'd8:    seg_hi = 7'b1111111;
            4'd9:    seg_hi = 7'b1111011;
            4'd10:   seg_hi = 7'b0000001;
            default: seg_hi = 7'b0000000;
        endcase
    end

    assign seg_o = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: double-buffered multi-digit scan with inter-digit blanking.
// Define SEVEN_SEG_LZ_SUPPRESS_EN to blank leading zeros when a frame is committed.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    output logic                      pending_o,
    output logic                      frame_tick,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic [6:0]                seg_out
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef logic [NUM_DIGITS-1:0][3:0] frame_t;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    frame_t            active_q, active_d, pending_q, pending_d;
    logic              pend_v_q, pend_v_d;
    logic              tick_q, tick_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]        code_q, code_d;
    logic              commit_pt;

    function automatic frame_t lz(input frame_t src);
        frame_t res;
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
        logic lead;
`endif
        res = src;
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead = lead && (src[i] == 4'd0);
            if (lead) res[i] = DIG_BLANK;
        end
`endif
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + 1'b1;
        active_d  = active_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        tick_d    = 1'b0;
        case (state_q)
            S_OFF: begin
                idx_d = '0;
                cnt_d = '0;
                state_d = enable ? S_ON : S_OFF;
            end
            S_ON: state_d = (cnt_q == ON_LAST) ? S_BLANK : S_ON;
            S_BLANK: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    tick_d  = (idx_q == IDX_LAST);
                end
            end
            default: state_d = S_OFF;
        endcase
        // Disabling abandons the frame: no tick, hence no commit.
        if (!enable) begin
            state_d = S_OFF;
            idx_d   = '0;
            cnt_d   = '0;
            tick_d  = 1'b0;
        end
        commit_pt = tick_d || (state_q == S_OFF && pend_v_q);
        if (commit_pt && (load || pend_v_q)) begin
            active_d = lz(load ? frame_t'(digits_in) : pending_q);
            pend_v_d = 1'b0;
        end else if (load) begin
            pending_d = frame_t'(digits_in);
            pend_v_d  = 1'b1;
        end
        an_d   = (state_d == S_ON) ? AN_OFF ^ (NUM_DIGITS'(1) << idx_d) : AN_OFF;
        code_d = (state_d == S_ON) ? active_d[idx_d] : DIG_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OFF;
            idx_q     <= '0;
            cnt_q     <= '0;
            active_q  <= {NUM_DIGITS{DIG_BLANK}};
            pending_q <= {NUM_DIGITS{DIG_BLANK}};
            pend_v_q  <= 1'b0;
            tick_q    <= 1'b0;
            an_q      <= AN_OFF;
            code_q    <= DIG_BLANK;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pend_v_q  <= pend_v_d;
            tick_q    <= tick_d;
            an_q      <= an_d;
            code_q    <= code_d;
        end
    end

    seven_seg_decoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
        .code_i(code_q),
        .seg_o (seg_out)
    );

    assign an_out     = an_q;
    assign pending_o  = pend_v_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: self-checking bench for seven_seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank).
// Honours SEVEN_SEG_LZ_SUPPRESS_EN for expected leading-zero behaviour.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0000100, SM = 7'b1111110, SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic        pending_o, frame_tick;
    logic [3:0]  an_out;
    logic [6:0]  seg_out;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
        .pending_o(pending_o), .frame_tick(frame_tick), .an_out(an_out), .seg_out(seg_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: position counted in cycles since scanning started.
    bit          m_on, m_pv, m_tick;
    int          m_pos;
    logic [15:0] m_disp, m_pend;
    logic [6:0]  seg_tab [16];

    typedef struct {
        logic [15:0]     din;
        logic [3:0][6:0] seg;
    } vec_t;
    vec_t tab [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] lz(input logic [15:0] v);
        logic [15:0] r;
        bit lead;
        r = v;
        lead = 1'b1;
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
        for (int d = 3; d > 0; d--) begin
            if (r[d*4 +: 4] != 4'd0) lead = 1'b0;
            if (lead) r[d*4 +: 4] = 4'hB;
        end
`endif
        return r;
    endfunction

    function automatic bit lit();
        return m_on && (m_pos % R) < (R - B);
    endfunction

    function automatic logic [3:0] exp_an();
        return lit() ? ~(4'b0001 << ((m_pos / R) % N)) : 4'hF;
    endfunction

    function automatic logic [6:0] exp_seg();
        int slot;
        slot = (m_pos / R) % N;
        return lit() ? seg_tab[m_disp[slot*4 +: 4]] : SB;
    endfunction

    task automatic model_reset();
        m_on = 0; m_pos = 0; m_pv = 0; m_tick = 0;
        m_disp = 16'hBBBB; m_pend = 16'hBBBB;
    endtask

    task automatic model_edge(input bit en, input bit ld, input logic [15:0] din);
        bit fe, cp;
        fe = m_on && en && (m_pos % (N*R) == N*R - 1);
        cp = fe || (!m_on && m_pv);
        if (cp && (ld || m_pv)) begin
            m_disp = lz(ld ? din : m_pend);
            m_pv = 0;
        end else if (ld) begin
            m_pend = din;
            m_pv = 1;
        end
        m_tick = fe;
        if (!en) m_on = 0;
        else if (!m_on) begin m_on = 1; m_pos = 0; end
        else m_pos++;
    endtask

    task automatic cyc(input bit en, input bit ld, input logic [15:0] din);
        enable = en; load = ld; digits_in = din;
        @(posedge clk);
        model_edge(en, ld, din);
        #1;
        chk("an_model", an_out, exp_an());
        chk("seg_model", seg_out, exp_seg());
        chk("pend_model", pending_o, m_pv);
        chk("tick_model", frame_tick, m_tick);
    endtask

    task automatic run_to_tick(input int max);
        int n;
        n = 0;
        do begin cyc(1, 0, 0); n++; end while (!frame_tick && n < max);
        chk("tick_reached", frame_tick, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"}, an_out, 4'hF);
        chk({tag, "_seg"}, seg_out, SB);
        chk({tag, "_pend"}, pending_o, 0);
        chk({tag, "_tick"}, frame_tick, 0);
    endtask

    initial begin
        int last, nt, n;
        bit en;
        seg_tab = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, SM, SB, SB, SB, SB, SB};
        tab[0] = '{16'h1234, {S1, S2, S3, S4}};
        tab[3] = '{16'hA005, {SM, S0, S0, S5}};
        tab[4] = '{16'hE9F6, {SB, S9, SB, S6}};
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
        tab[1] = '{16'h0070, {SB, SB, S7, S0}};
        tab[2] = '{16'h0000, {SB, SB, SB, S0}};
`else
        tab[1] = '{16'h0070, {S0, S0, S7, S0}};
        tab[2] = '{16'h0000, {S0, S0, S0, S0}};
`endif
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0);
        check_reset_outputs("idle");

        // Load while off, then scan: exact slot timing.
        cyc(0, 1, 16'h1234);
        chk("pend_after_load", pending_o, 1);
        cyc(1, 0, 0);
        chk("first_an", an_out, 4'b1110);
        chk("first_seg", seg_out, S4);
        for (int i = 0; i < 5; i++) begin cyc(1, 0, 0); chk("d0_hold", an_out, 4'b1110); end
        for (int i = 0; i < 2; i++) begin cyc(1, 0, 0); chk("blank_gap", an_out, 4'hF); end
        cyc(1, 0, 0);
        chk("d1_an", an_out, 4'b1101);
        chk("d1_seg", seg_out, S3);
        last = -1; nt = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(1, 0, 0);
            if (frame_tick) begin
                if (last >= 0) chk("tick_period", i - last, 32);
                last = i; nt++;
            end
        end
        chk("ticks_seen", nt >= 2, 1);

        // Mid-frame load waits for the frame boundary.
        run_to_tick(40);
        repeat (3) cyc(1, 0, 0);
        cyc(1, 1, 16'h5678);
        chk("mid_pend", pending_o, 1);
        run_to_tick(40);
        chk("commit_an", an_out, 4'b1110);
        chk("commit_seg", seg_out, S8);
        chk("commit_pend", pending_o, 0);

        // Last load wins.
        repeat (4) cyc(1, 0, 0);
        cyc(1, 1, 16'h1111);
        repeat (3) cyc(1, 0, 0);
        cyc(1, 1, 16'h2222);
        run_to_tick(40);
        chk("lastwins_seg", seg_out, S2);

        // Load on the commit cycle bypasses a stale pending value.
        repeat (2) cyc(1, 0, 0);
        cyc(1, 1, 16'h9999);
        n = 0;
        while (!(m_on && m_pos % (N*R) == N*R - 1) && n < 40) begin cyc(1, 0, 0); n++; end
        cyc(1, 1, 16'h4321);
        chk("bypass_tick", frame_tick, 1);
        chk("bypass_pend", pending_o, 0);
        chk("bypass_seg", seg_out, S1);

        // Enable dropped during digit 2.
        n = 0;
        while (an_out != 4'b1011 && n < 40) begin cyc(1, 0, 0); n++; end
        chk("at_d2", an_out, 4'b1011);
        cyc(0, 0, 0);
        chk("drop_an", an_out, 4'hF);
        repeat (2) cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("restart_an", an_out, 4'b1110);

        // Table vectors: load while off, then read every digit once.
        foreach (tab[k]) begin
            cyc(0, 1, tab[k].din);
            cyc(0, 0, 0);
            cyc(1, 0, 0);
            for (int s = 0; s < N; s++) begin
                chk($sformatf("tab%0d_d%0d", k, s), seg_out, tab[k].seg[s]);
                if (s < N - 1) repeat (R) cyc(1, 0, 0);
            end
        end

        // Randomised traffic against the model.
        en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) en = !en;
            cyc(en, $urandom_range(0, 11) == 0, 16'($urandom));
        end

        // Asynchronous reset mid-slot.
        cyc(1, 1, 16'h8888);
        repeat (3) cyc(1, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0);
        check_reset_outputs("post_async");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
